axi_wr_arbiter: RTL and testbench
=================================

Name: axi_wr_arbiter

Overview:
- Two-requester write-channel arbiter that shares one AXI4 write master port between two wr_channel-style requesters, e.g. a video write path and a DMA write path.
- Grants the AW/W/B channels to one requester per burst under round-robin priority.
- Allows one outstanding burst at a time and generates WLAST from its own beat counter.
- Sits between the requesters' AXI master outputs and the DDR controller slave port, in the axi_clk domain.

Parameters:
AXI_ADDR_WIDTH, 32, address width
AXI_DATA_WIDTH, 128, data width; strobe width is AXI_DATA_WIDTH/8

Ports:
axi_clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
s{0,1}_awvalid  in  1  requester address valid
s{0,1}_awready  out  1  requester address accepted
s{0,1}_awaddr  in  AXI_ADDR_WIDTH  burst start address
s{0,1}_awlen  in  8  beats minus 1
s{0,1}_wvalid  in  1  write data valid
s{0,1}_wready  out  1  write data accepted
s{0,1}_wdata  in  AXI_DATA_WIDTH  write data
s{0,1}_wstrb  in  AXI_DATA_WIDTH/8  byte strobes
s{0,1}_wlast  in  1  requester last beat, checked only
s{0,1}_bvalid  out  1  response valid
s{0,1}_bready  in  1  response accepted
s{0,1}_bresp  out  2  response code
m_axi_awvalid/awready/awaddr/awlen/awid(4)  out/in/out/out/out  AXI AW channel
m_axi_wvalid/wready/wdata/wstrb/wlast  out/in/out/out/out  AXI W channel
m_axi_bvalid/bready/bresp/bid(4)  in/out/in/in  AXI B channel
grant  out  1  index of the granted requester
busy  out  1  high while not in IDLE
err_wlast  out  1  sticky: requester WLAST misaligned with awlen
err_bresp  out  1  sticky: non-OKAY or wrong BID response

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant=1 so port 0 wins the first tie, beat_cnt=0, sticky errors cleared. Reset mid-burst aborts the burst immediately with no drain.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - sel = the sole requester with awvalid high; if both are high, sel = ~last_grant.
  - s{sel}_awready=1 combinationally; the other awready=0.
  - On the handshake: capture awaddr/awlen into registers, set grant=sel, go to ADDR.
  - Latency: request to m_axi_awvalid is 1 cycle.
- ADDR:
  - m_axi_awvalid=1; awaddr/awlen come from the registers and stay stable while stalled.
  - m_axi_awid={3'b000,grant}.
  - On m_axi_awready: go to DATA, beat_cnt=0.
- DATA:
  - m_axi_wvalid=s{grant}_wvalid; s{grant}_wready=m_axi_wready; wdata/wstrb passed through combinationally.
  - m_axi_wlast=(beat_cnt==awlen_reg) whenever wvalid is high.
  - beat_cnt (8 bit) increments on each W handshake.
  - On the handshake with beat_cnt==awlen_reg: go to RESP.
  - err_wlast is set on any handshake where s{grant}_wlast != (beat_cnt==awlen_reg). The burst still ends on the counter, so early or missing wlast never hangs the port.
- RESP:
  - s{grant}_bvalid=m_axi_bvalid; m_axi_bready=s{grant}_bready; bresp passed through.
  - On the handshake: last_grant=grant, go to IDLE.
  - err_bresp is set if bresp!=2'b00 or bid!={3'b000,grant}.
- The non-granted requester always sees awready=wready=bvalid=0 and bresp=0. Its awvalid may stay asserted; it is served at the next IDLE.
- The AW handshake cannot occur outside IDLE, so arbitration never changes mid-burst and at most one burst is outstanding.
- awlen=0 gives a single beat with wlast high on the first beat.
- The minimum burst cycle is AW(1) + ADDR(1) + beats + RESP(1).
- Each requester holds its AW payload stable until awready, per AXI.

Test Plan:
1. Only s0 requests, awaddr=0x1000, awlen=3, m side always ready -> m_axi_awaddr=0x1000, awlen=3, awid=0; 4 beats with wlast on the 4th; s0_bvalid pulses; grant=0; errors 0.
2. s0 and s1 assert awvalid together and hold for 4 bursts of awlen=0 -> grants alternate 0,1,0,1; s1_awready stays 0 while s0 is active.
3. m_axi_awready held low 5 cycles, then wready toggling 1/0 during an awlen=7 burst -> awaddr stable while stalled; exactly 8 W handshakes; wlast only on the 8th.
4. s1 burst with awlen=3 and s1_wlast on beat 2 -> err_wlast=1 (sticky); m_axi_wlast still on beat 4; FSM returns to IDLE after B.
5. Return bresp=2'b10 for an s0 burst -> s0_bresp=2'b10 and err_bresp=1; the next s1 burst proceeds normally.
6. Assert reset during DATA at beat 2 -> all outputs 0 next edge, state IDLE; a following s1 request is granted first (last_grant=1 is reset, so s0 wins only ties).

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI4 write arbiter: one burst at a time, round-robin grant,
// WLAST regenerated from an internal beat counter.
module axi_wr_arbiter #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 128
) (
  input  logic                        axi_clk,
  input  logic                        reset,
  input  logic                        s0_awvalid,
  output logic                        s0_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s0_awaddr,
  input  logic [7:0]                  s0_awlen,
  input  logic                        s0_wvalid,
  output logic                        s0_wready,
  input  logic [AXI_DATA_WIDTH-1:0]   s0_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s0_wstrb,
  input  logic                        s0_wlast,
  output logic                        s0_bvalid,
  input  logic                        s0_bready,
  output logic [1:0]                  s0_bresp,
  input  logic                        s1_awvalid,
  output logic                        s1_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s1_awaddr,
  input  logic [7:0]                  s1_awlen,
  input  logic                        s1_wvalid,
  output logic                        s1_wready,
  input  logic [AXI_DATA_WIDTH-1:0]   s1_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s1_wstrb,
  input  logic                        s1_wlast,
  output logic                        s1_bvalid,
  input  logic                        s1_bready,
  output logic [1:0]                  s1_bresp,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [3:0]                  m_axi_awid,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic [3:0]                  m_axi_bid,
  output logic                        grant,
  output logic                        busy,
  output logic                        err_wlast,
  output logic                        err_bresp
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t                    state;
  logic                      last_grant;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]                awlen_q;
  logic [7:0]                beat_cnt;

  logic sel;
  logic aw_req;
  logic in_idle;
  logic in_data;
  logic in_resp;
  logic last_beat;
  logic g_wvalid;
  logic g_wlast;
  logic g_bready;
  logic w_hs;
  logic b_hs;

  always_comb begin
    sel = 1'b0;
    unique case (1'b1)
      s0_awvalid && s1_awvalid:  sel = ~last_grant;
      s1_awvalid && !s0_awvalid: sel = 1'b1;
      default:                   sel = 1'b0;
    endcase
  end

  assign aw_req    = s0_awvalid | s1_awvalid;
  assign in_idle   = (state == IDLE);
  assign in_data   = (state == DATA);
  assign in_resp   = (state == RESP);
  assign last_beat = (beat_cnt == awlen_q);

  assign g_wvalid = grant ? s1_wvalid : s0_wvalid;
  assign g_wlast  = grant ? s1_wlast  : s0_wlast;
  assign g_bready = grant ? s1_bready : s0_bready;

  assign s0_awready = in_idle & aw_req & ~sel;
  assign s1_awready = in_idle & aw_req & sel;

  assign m_axi_awvalid = (state == ADDR);
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awid    = {3'b000, grant};

  // W path is muted outside DATA so idle data never leaks downstream
  assign m_axi_wvalid = in_data & g_wvalid;
  assign m_axi_wlast  = m_axi_wvalid & last_beat;
  assign m_axi_wdata  = !in_data ? '0 :
                        grant ? s1_wdata : s0_wdata;
  assign m_axi_wstrb  = !in_data ? '0 :
                        grant ? s1_wstrb : s0_wstrb;
  assign s0_wready    = in_data & ~grant & m_axi_wready;
  assign s1_wready    = in_data & grant & m_axi_wready;
  assign w_hs         = m_axi_wvalid & m_axi_wready;

  assign m_axi_bready = in_resp & g_bready;
  assign s0_bvalid    = in_resp & ~grant & m_axi_bvalid;
  assign s1_bvalid    = in_resp & grant & m_axi_bvalid;
  assign s0_bresp     = (in_resp & ~grant) ? m_axi_bresp : 2'b00;
  assign s1_bresp     = (in_resp & grant) ? m_axi_bresp : 2'b00;
  assign b_hs         = in_resp & m_axi_bvalid & g_bready;

  assign busy = ~in_idle;

  always_ff @(posedge axi_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      beat_cnt   <= '0;
      err_wlast  <= 1'b0;
      err_bresp  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_req) begin
            grant    <= sel;
            awaddr_q <= sel ? s1_awaddr : s0_awaddr;
            awlen_q  <= sel ? s1_awlen : s0_awlen;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_awready) begin
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (g_wlast != last_beat) err_wlast <= 1'b1;
            // the counter, not the requester's wlast, ends the burst
            if (last_beat) state <= RESP;
            else beat_cnt <= beat_cnt + 8'd1;
          end
        end
        RESP: begin
          if (b_hs) begin
            if (m_axi_bresp != 2'b00 ||
                m_axi_bid != {3'b000, grant})
              err_bresp <= 1'b1;
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: random requester/slave traffic checked
// cycle by cycle against a burst-level transaction model.
`timescale 1ns/1ps
module tb_axi_wr_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int SW = DW / 8;
  localparam int P_IDLE = 0;
  localparam int P_ADDR = 1;
  localparam int P_DATA = 2;
  localparam int P_RESP = 3;

  logic          axi_clk = 1'b0;
  logic          reset;
  logic          s0_awvalid, s0_awready, s0_wvalid, s0_wready;
  logic [AW-1:0] s0_awaddr;
  logic [7:0]    s0_awlen;
  logic [DW-1:0] s0_wdata;
  logic [SW-1:0] s0_wstrb;
  logic          s0_wlast, s0_bvalid, s0_bready;
  logic [1:0]    s0_bresp;
  logic          s1_awvalid, s1_awready, s1_wvalid, s1_wready;
  logic [AW-1:0] s1_awaddr;
  logic [7:0]    s1_awlen;
  logic [DW-1:0] s1_wdata;
  logic [SW-1:0] s1_wstrb;
  logic          s1_wlast, s1_bvalid, s1_bready;
  logic [1:0]    s1_bresp;
  logic          m_axi_awvalid, m_axi_awready;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [3:0]    m_axi_awid;
  logic          m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [DW-1:0] m_axi_wdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_bvalid, m_axi_bready;
  logic [1:0]    m_axi_bresp;
  logic [3:0]    m_axi_bid;
  logic          grant, busy, err_wlast, err_bresp;

  always #5 axi_clk = ~axi_clk;

  axi_wr_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .axi_clk(axi_clk), .reset(reset),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen),
    .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast),
    .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_bresp(s0_bresp),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen),
    .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
    .s1_bvalid(s1_bvalid), .s1_bready(s1_bready), .s1_bresp(s1_bresp),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awid(m_axi_awid),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bid(m_axi_bid),
    .grant(grant), .busy(busy),
    .err_wlast(err_wlast), .err_bresp(err_bresp)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    int          bad_beat;
    logic [1:0]  bresp;
    bit          bad_bid;
  } burst_t;

  burst_t q0[$];
  burst_t q1[$];
  burst_t cur;
  int     gseq[$];
  int     ph, beats, done, cyc;
  bit     cg, lg, e_wl, e_br, wr_toggle;
  int     p_awr, p_wr, p_bv, p_wv, p_br;
  int     checks = 0;
  int     failures = 0;

  function automatic bit roll(input int p);
    return $urandom_range(99) < p;
  endfunction

  function automatic burst_t mk(input logic [31:0] a, input logic [7:0] l,
                                input int bb, input logic [1:0] br,
                                input bit bid_bad);
    burst_t b;
    b.addr = a; b.len = l; b.bad_beat = bb;
    b.bresp = br; b.bad_bid = bid_bad;
    return b;
  endfunction

  task automatic knobs(input int awr, input int wr, input int bv,
                       input int wv, input int br);
    p_awr = awr; p_wr = wr; p_bv = bv; p_wv = wv; p_br = br;
  endtask

  task automatic clear_inputs();
    s0_awvalid = 0; s0_awaddr = '0; s0_awlen = '0; s0_wvalid = 0;
    s0_wdata = '0; s0_wstrb = '0; s0_wlast = 0; s0_bready = 0;
    s1_awvalid = 0; s1_awaddr = '0; s1_awlen = '0; s1_wvalid = 0;
    s1_wdata = '0; s1_wstrb = '0; s1_wlast = 0; s1_bready = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
    m_axi_bresp = '0; m_axi_bid = '0;
  endtask

  task automatic model_reset();
    ph = P_IDLE; beats = 0; done = 0; cg = 0; lg = 1;
    e_wl = 0; e_br = 0; wr_toggle = 0;
    q0.delete(); q1.delete(); gseq.delete();
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    @(posedge axi_clk); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({s0_awready, s1_awready, s0_wready, s1_wready, s0_bvalid, s1_bvalid,
         s0_bresp, s1_bresp, m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
         m_axi_awid, m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
         m_axi_bready, grant, busy, err_wlast, err_bresp} !== '0) begin
      failures++;
      $display("FAIL %s outputs not zero: awv=%b wv=%b busy=%b grant=%b addr=%h err=%b%b required all 0",
               name, m_axi_awvalid, m_axi_wvalid, busy, grant, m_axi_awaddr,
               err_wlast, err_bresp);
    end
  endtask

  // One clock of traffic: drive, sample mid-cycle, check, advance the model.
  task automatic step();
    bit p0, p1, sel, a0, a1, wv, lb, wl;
    logic [3:0]  e_aw, o_aw, e_w, o_w;
    logic [6:0]  e_b, o_b;
    logic [3:0]  e_st, o_st;
    p0 = q0.size() != 0;
    p1 = q1.size() != 0;
    s0_awvalid = p0;
    s1_awvalid = p1;
    if (p0) begin s0_awaddr = q0[0].addr; s0_awlen = q0[0].len; end
    else begin s0_awaddr = $urandom; s0_awlen = 8'($urandom); end
    if (p1) begin s1_awaddr = q1[0].addr; s1_awlen = q1[0].len; end
    else begin s1_awaddr = $urandom; s1_awlen = 8'($urandom); end
    s0_wvalid = roll(p_wv);
    s1_wvalid = roll(p_wv);
    s0_wdata = {$urandom, $urandom, $urandom, $urandom};
    s1_wdata = {$urandom, $urandom, $urandom, $urandom};
    s0_wstrb = SW'($urandom);
    s1_wstrb = SW'($urandom);
    s0_wlast = 1'($urandom);
    s1_wlast = 1'($urandom);
    if (ph == P_DATA) begin
      wl = (cur.bad_beat >= 0) ? (beats == cur.bad_beat)
                               : (beats == int'(cur.len));
      if (cg) s1_wlast = wl; else s0_wlast = wl;
    end
    s0_bready = roll(p_br);
    s1_bready = roll(p_br);
    m_axi_awready = roll(p_awr);
    m_axi_wready = wr_toggle ? (cyc % 2 == 1) : roll(p_wr);
    m_axi_bvalid = (ph == P_RESP) && roll(p_bv);
    m_axi_bresp = (ph == P_RESP) ? cur.bresp : 2'($urandom);
    m_axi_bid = {3'b000, cg ^ ((ph == P_RESP) && cur.bad_bid)};
    #4;
    sel = (p0 && p1) ? !lg : p1;
    a0 = (ph == P_IDLE) && (p0 || p1) && !sel;
    a1 = (ph == P_IDLE) && (p0 || p1) && sel;
    wv = cg ? s1_wvalid : s0_wvalid;
    lb = (beats == int'(cur.len));

    e_aw = {a0, a1, ph == P_ADDR, 1'b0};
    o_aw = {s0_awready, s1_awready, m_axi_awvalid, 1'b0};
    checks++;
    if (o_aw !== e_aw) begin
      failures++;
      $display("FAIL aw_ctl phase=%0d got=%b required=%b", ph, o_aw, e_aw);
    end
    if (ph == P_ADDR) begin
      checks++;
      if ({m_axi_awaddr, m_axi_awlen, m_axi_awid} !==
          {cur.addr, cur.len, 3'b000, cg}) begin
        failures++;
        $display("FAIL aw_payload got=%h/%0d/%0d required=%h/%0d/%0d",
                 m_axi_awaddr, m_axi_awlen, m_axi_awid, cur.addr, cur.len, cg);
      end
    end

    e_w = (ph == P_DATA) ? {wv, !cg && m_axi_wready, cg && m_axi_wready, wv && lb}
                         : 4'b0000;
    o_w = {m_axi_wvalid, s0_wready, s1_wready, m_axi_wlast};
    checks++;
    if (o_w !== e_w) begin
      failures++;
      $display("FAIL w_ctl phase=%0d beat=%0d got=%b required=%b",
               ph, beats, o_w, e_w);
    end
    if (ph == P_DATA && wv) begin
      checks++;
      if ({m_axi_wdata, m_axi_wstrb} !==
          (cg ? {s1_wdata, s1_wstrb} : {s0_wdata, s0_wstrb})) begin
        failures++;
        $display("FAIL w_data got=%h/%h grant=%0d", m_axi_wdata, m_axi_wstrb, cg);
      end
    end

    e_b = (ph == P_RESP) ?
          {!cg && m_axi_bvalid, cg && m_axi_bvalid,
           cg ? 2'b00 : m_axi_bresp, cg ? m_axi_bresp : 2'b00,
           cg ? s1_bready : s0_bready} : 7'b0;
    o_b = {s0_bvalid, s1_bvalid, s0_bresp, s1_bresp, m_axi_bready};
    checks++;
    if (o_b !== e_b) begin
      failures++;
      $display("FAIL b_ctl phase=%0d got=%b required=%b", ph, o_b, e_b);
    end

    e_st = {ph != P_IDLE, cg, e_wl, e_br};
    o_st = {busy, grant, err_wlast, err_bresp};
    checks++;
    if (o_st !== e_st) begin
      failures++;
      $display("FAIL status busy/grant/err_wlast/err_bresp got=%b required=%b",
               o_st, e_st);
    end

    case (ph)
      P_IDLE: if (p0 || p1) begin
        cg = sel;
        if (sel) cur = q1.pop_front(); else cur = q0.pop_front();
        gseq.push_back(int'(sel));
        ph = P_ADDR;
      end
      P_ADDR: if (m_axi_awready) begin
        ph = P_DATA;
        beats = 0;
      end
      P_DATA: if (m_axi_wready && wv) begin
        if ((cg ? s1_wlast : s0_wlast) != lb) e_wl = 1;
        if (lb) ph = P_RESP; else beats++;
      end
      default: if (m_axi_bvalid && (cg ? s1_bready : s0_bready)) begin
        if (cur.bresp != 2'b00 || cur.bad_bid) e_br = 1;
        lg = cg;
        ph = P_IDLE;
        done++;
      end
    endcase
    @(posedge axi_clk); #1;
    cyc++;
  endtask

  task automatic run(input int n, input int budget);
    int c;
    c = 0;
    while (done < n && c < budget) begin
      step();
      c++;
    end
    checks++;
    if (done < n) begin
      failures++;
      $display("FAIL run_timeout completed=%0d required=%0d", done, n);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    s0_wvalid = 1; s1_wvalid = 1; m_axi_bvalid = 1;
    s0_wdata = '1; m_axi_bresp = 2'b11;
    reset = 1;
    #2;
    check_zero("reset_async");
    @(posedge axi_clk); #1;
    check_zero("reset_held");
    clear_inputs();
    reset = 0;
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    knobs(100, 100, 100, 100, 100);
    q0.push_back(mk(32'h1000, 8'd3, -1, 2'b00, 0));
    run(1, 30);
    checks++;
    if ({grant, err_wlast, err_bresp} !== 3'b000) begin
      failures++;
      $display("FAIL single_status got=%b required=000",
               {grant, err_wlast, err_bresp});
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    knobs(100, 100, 100, 100, 100);
    for (int i = 0; i < 2; i++) begin
      q0.push_back(mk($urandom, 8'd0, -1, 2'b00, 0));
      q1.push_back(mk($urandom, 8'd0, -1, 2'b00, 0));
    end
    run(4, 60);
    checks++;
    if (gseq.size() != 4 || gseq[0] != 0 || gseq[1] != 1 ||
        gseq[2] != 0 || gseq[3] != 1) begin
      failures++;
      $display("FAIL rr_order got=%p required=0,1,0,1", gseq);
    end
  endtask

  task automatic test_stall();
    do_reset();
    knobs(0, 100, 100, 100, 100);
    q0.push_back(mk(32'h2000_0040, 8'd7, -1, 2'b00, 0));
    for (int i = 0; i < 6; i++) step();
    p_awr = 100;
    wr_toggle = 1;
    run(1, 60);
    wr_toggle = 0;
  endtask

  task automatic test_bad_wlast();
    do_reset();
    knobs(100, 100, 100, 100, 100);
    q1.push_back(mk(32'h3000, 8'd3, 1, 2'b00, 0));
    run(1, 30);
    step();
    checks++;
    if ({err_wlast, busy} !== 2'b10) begin
      failures++;
      $display("FAIL bad_wlast err_wlast/busy got=%b required=10",
               {err_wlast, busy});
    end
  endtask

  task automatic test_bad_bresp();
    do_reset();
    knobs(100, 100, 100, 100, 100);
    q0.push_back(mk(32'h4000, 8'd1, -1, 2'b10, 0));
    run(1, 30);
    q1.push_back(mk(32'h5000, 8'd2, -1, 2'b00, 0));
    run(2, 30);
    checks++;
    if ({err_bresp, err_wlast, grant} !== 3'b101) begin
      failures++;
      $display("FAIL bad_bresp err_bresp/err_wlast/grant got=%b required=101",
               {err_bresp, err_wlast, grant});
    end
  endtask

  task automatic test_mid_reset();
    int c;
    do_reset();
    knobs(100, 100, 100, 100, 100);
    q0.push_back(mk(32'h6000, 8'd7, -1, 2'b00, 0));
    c = 0;
    while (!(ph == P_DATA && beats == 2) && c < 20) begin
      step();
      c++;
    end
    clear_inputs();
    reset = 1;
    #2;
    check_zero("mid_reset_async");
    @(posedge axi_clk); #1;
    check_zero("mid_reset_held");
    reset = 0;
    model_reset();
    q1.push_back(mk(32'h7000, 8'd1, -1, 2'b00, 0));
    run(1, 30);
    checks++;
    if (gseq.size() == 0 || gseq[0] != 1) begin
      failures++;
      $display("FAIL after_reset_grant got=%p required=1", gseq);
    end
  endtask

  task automatic test_random();
    int l;
    do_reset();
    knobs($urandom_range(100, 30), $urandom_range(100, 30),
          $urandom_range(100, 30), $urandom_range(100, 30),
          $urandom_range(100, 30));
    for (int i = 0; i < 20; i++) begin
      l = $urandom_range(15);
      if (i % 2 == 0)
        q0.push_back(mk($urandom, 8'(l),
                        ($urandom_range(9) == 0) ? $urandom_range(l) : -1,
                        ($urandom_range(9) == 0) ? 2'($urandom) : 2'b00,
                        $urandom_range(14) == 0));
      else
        q1.push_back(mk($urandom, 8'(l),
                        ($urandom_range(9) == 0) ? $urandom_range(l) : -1,
                        ($urandom_range(9) == 0) ? 2'($urandom) : 2'b00,
                        $urandom_range(14) == 0));
    end
    run(20, 4000);
  endtask

  initial begin
    cyc = 0;
    clear_inputs();
    reset = 1;
    model_reset();
    @(posedge axi_clk); #1;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_bad_wlast();
    test_bad_bresp();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
